decode_stage: RTL and testbench

Instruction decode / register-read stage of the RV32I pipeline. It sits directly upstream of the regfile read ports and downstream of fetch.
- Decodes the instruction and drives the regfile read selects.
- Bypasses same-cycle writeback data.
- Interlocks on a 32-entry pending-write scoreboard.
- Registers decoded operands into a valid/ready pipeline register feeding execute.

---
 rtl/decode_stage.sv | 161 ++++++++++++++++
 tb/tb_decode_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode/register-read stage with writeback bypass and pending-write interlock
module decode_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [4:0]      readPort1SEL,
    output logic [4:0]      readPort2SEL,
    input  logic [XLEN-1:0] readPort1,
    input  logic [XLEN-1:0] readPort2,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_writes_rd,
    output logic            ex_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [4:0]      rs1, rs2, rd;
    logic            usesRs1, usesRs2, writesKind, legal, writesRd;
    logic [31:0]     imm;
    logic [XLEN-1:0] rs1Val, rs2Val;
    logic            hazard1, hazard2, fire;
    logic [31:0]     scoreboard, scoreboardNext;

    assign rs1          = instr[19:15];
    assign rs2          = instr[24:20];
    assign rd           = instr[11:7];
    assign readPort1SEL = rs1;
    assign readPort2SEL = rs2;

    // Every legal opcode has instr[1:0]==2'b11, so compressed encodings land in default.
    always_comb begin
        usesRs1    = 1'b0;
        usesRs2    = 1'b0;
        writesKind = 1'b0;
        legal      = 1'b1;
        imm        = 32'h0;
        case (instr[6:0])
            OP_LUI, OP_AUIPC: begin
                writesKind = 1'b1;
                imm        = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                writesKind = 1'b1;
                imm        = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                writesKind = 1'b1;
                usesRs1    = 1'b1;
                imm        = {{20{instr[31]}}, instr[31:20]};
            end
            OP_BRANCH: begin
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
                imm     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_STORE: begin
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
                imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_OP: begin
                writesKind = 1'b1;
                usesRs1    = 1'b1;
                usesRs2    = 1'b1;
            end
            OP_MISC, OP_SYSTEM: imm = {{20{instr[31]}}, instr[31:20]};
            default: legal = 1'b0;
        endcase
    end

    assign writesRd = writesKind && (rd != 5'd0);

    assign rs1Val = (rs1 == 5'd0) ? '0 : (wb_we && wb_rd == rs1) ? wb_data : readPort1;
    assign rs2Val = (rs2 == 5'd0) ? '0 : (wb_we && wb_rd == rs2) ? wb_data : readPort2;

    // A writeback landing this cycle releases the scoreboard bit early; the bypass covers the data.
    assign hazard1 = usesRs1 && (rs1 != 5'd0) &&
                     ((scoreboard[rs1] && !(wb_we && wb_rd == rs1)) ||
                      (ex_valid && ex_writes_rd && ex_rd == rs1));
    assign hazard2 = usesRs2 && (rs2 != 5'd0) &&
                     ((scoreboard[rs2] && !(wb_we && wb_rd == rs2)) ||
                      (ex_valid && ex_writes_rd && ex_rd == rs2));

    assign instr_ready = rst_n && !flush && !hazard1 && !hazard2 && (!ex_valid || ex_ready);
    assign fire        = instr_valid && instr_ready;

    always_comb begin
        scoreboardNext = scoreboard;
        if (wb_we)
            scoreboardNext[wb_rd] = 1'b0;
        if (ex_valid && ex_ready && ex_writes_rd && !flush)
            scoreboardNext[ex_rd] = 1'b1;
        scoreboardNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scoreboard   <= '0;
            ex_valid     <= 1'b0;
            ex_pc        <= RESET_PC;
            ex_rs1_val   <= '0;
            ex_rs2_val   <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_opcode    <= '0;
            ex_funct3    <= '0;
            ex_funct7b5  <= 1'b0;
            ex_writes_rd <= 1'b0;
            ex_illegal   <= 1'b0;
        end else begin
            scoreboard <= scoreboardNext;
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (fire) begin
                ex_valid     <= 1'b1;
                ex_pc        <= pc;
                ex_rs1_val   <= rs1Val;
                ex_rs2_val   <= rs2Val;
                ex_imm       <= imm;
                ex_rd        <= writesRd ? rd : 5'd0;
                ex_opcode    <= instr[6:0];
                ex_funct3    <= instr[14:12];
                ex_funct7b5  <= instr[30];
                ex_writes_rd <= writesRd;
                ex_illegal   <= !legal;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed scoreboard bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, pc;
    logic [4:0]  readPort1SEL, readPort2SEL;
    logic [31:0] readPort1, readPort2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5, ex_writes_rd, ex_illegal;

    decode_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc(pc),
        .readPort1SEL(readPort1SEL), .readPort2SEL(readPort2SEL),
        .readPort1(readPort1), .readPort2(readPort2),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .ex_writes_rd(ex_writes_rd), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, rs1v, rs2v, imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7, wr, ill;
    } exp_t;

    exp_t q[$];
    exp_t nxt;
    logic expExValid;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p);
        instr       = i;
        pc          = p;
        instr_valid = 1'b1;
    endtask

    task automatic expect_op(input logic [31:0] r1v, input logic [31:0] r2v, input logic [31:0] im,
                             input logic [4:0] rdx, input logic wr, input logic ill);
        logic [31:0] w;
        w        = instr;
        nxt.pc   = pc;
        nxt.rs1v = r1v;
        nxt.rs2v = r2v;
        nxt.imm  = im;
        nxt.rd   = rdx;
        nxt.op   = w[6:0];
        nxt.f3   = w[14:12];
        nxt.f7   = w[30];
        nxt.wr   = wr;
        nxt.ill  = ill;
    endtask

    task automatic cycle(input logic expReady);
        exp_t f;
        logic fired;
        @(negedge clk);
        check("instr_ready", instr_ready, expReady);
        check("ex_valid", ex_valid, expExValid);
        if (expExValid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_underflow observed=empty expected=entry");
            end else begin
                f = q[0];
                check("ex_pc", ex_pc, f.pc);
                check("ex_rs1_val", ex_rs1_val, f.rs1v);
                check("ex_rs2_val", ex_rs2_val, f.rs2v);
                check("ex_imm", ex_imm, f.imm);
                check("ex_rd", ex_rd, f.rd);
                check("ex_opcode", ex_opcode, f.op);
                check("ex_funct3", ex_funct3, f.f3);
                check("ex_funct7b5", ex_funct7b5, f.f7);
                check("ex_writes_rd", ex_writes_rd, f.wr);
                check("ex_illegal", ex_illegal, f.ill);
                if (ex_ready || flush)
                    void'(q.pop_front());
            end
        end
        fired = instr_valid && expReady;
        if (fired)
            q.push_back(nxt);
        expExValid = fired || (expExValid && !ex_ready && !flush);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b1; instr = 32'h0050_0093; pc = 32'h10;
        ex_ready = 1'b1; flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        readPort1 = 32'h0; readPort2 = 32'h0; expExValid = 1'b0;

        repeat (2) begin
            @(negedge clk);
            check("rst_instr_ready", instr_ready, 1'b0);
            check("rst_ex_valid", ex_valid, 1'b0);
            check("rst_ex_pc", ex_pc, 32'h0);
            check("rst_ex_imm", ex_imm, 32'h0);
            check("rst_ex_rd", ex_rd, 5'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // addi x1,x0,5
        drive(32'h0050_0093, 32'h10); readPort1 = 32'hDEAD; readPort2 = 32'h22;
        expect_op(32'h0, 32'h22, 32'h5, 5'd1, 1'b1, 1'b0);
        cycle(1'b1);

        // add x3,x1,x2 stalls on in-flight x1, then on scoreboard, then fires with bypass
        drive(32'h0020_81B3, 32'h14); readPort1 = 32'h99; readPort2 = 32'h7;
        expect_op(32'h5, 32'h7, 32'h0, 5'd3, 1'b1, 1'b0);
        cycle(1'b0);
        cycle(1'b0);
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h5;
        cycle(1'b1);
        wb_we = 1'b0;

        // backpressure holds add x3 for three cycles
        ex_ready = 1'b0;
        drive(32'hFE20_8EE3, 32'h18); readPort1 = 32'h11; readPort2 = 32'h7;
        expect_op(32'h11, 32'h7, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0);
        ex_ready = 1'b1;
        cycle(1'b1);

        // lui x7 / lw x5 back to back
        drive(32'h1234_53B7, 32'h1C); readPort1 = 32'h81; readPort2 = 32'h33;
        expect_op(32'h81, 32'h33, 32'h1234_5000, 5'd7, 1'b1, 1'b0);
        cycle(1'b1);
        drive(32'h0081_2283, 32'h20); readPort1 = 32'h1000; readPort2 = 32'h55;
        expect_op(32'h1000, 32'h55, 32'h8, 5'd5, 1'b1, 1'b0);
        cycle(1'b1);

        // addi x6 then flushed; x6 must not be marked pending
        drive(32'h0010_0313, 32'h24); readPort1 = 32'h3; readPort2 = 32'h4;
        expect_op(32'h0, 32'h4, 32'h1, 5'd6, 1'b1, 1'b0);
        cycle(1'b1);
        flush = 1'b1;
        drive(32'h0003_0433, 32'h28); readPort1 = 32'h66; readPort2 = 32'h77;
        cycle(1'b0);
        flush = 1'b0;
        expect_op(32'h66, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0);
        cycle(1'b1);

        // illegal all-zero word
        drive(32'h0000_0000, 32'h2C);
        expect_op(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        cycle(1'b1);

        // addi x4 retires in execute while an older x4 writes back: set wins
        drive(32'h0030_0213, 32'h30);
        expect_op(32'h0, 32'h77, 32'h3, 5'd4, 1'b1, 1'b0);
        cycle(1'b1);
        drive(32'h0002_04B3, 32'h34); instr_valid = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'hAB;
        cycle(1'b0);
        wb_we = 1'b0; instr_valid = 1'b1; readPort1 = 32'h1;
        cycle(1'b0);
        cycle(1'b0);
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
        expect_op(32'h44, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0);
        cycle(1'b1);
        wb_we = 1'b0;

        // hold add x9, then reset mid-operation
        ex_ready = 1'b0; instr_valid = 1'b0;
        cycle(1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_ex_valid", ex_valid, 1'b0);
        check("midrst_instr_ready", instr_ready, 1'b0);
        check("midrst_ex_pc", ex_pc, 32'h0);
        check("midrst_ex_rd", ex_rd, 5'd0);
        check("midrst_ex_rs1_val", ex_rs1_val, 32'h0);
        q.delete();
        expExValid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; ex_ready = 1'b1;

        // x5 was pending before reset; scoreboard must be clear now
        drive(32'h0002_8533, 32'h40); readPort1 = 32'h5A;
        expect_op(32'h5A, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0);
        cycle(1'b1);
        instr_valid = 1'b0;
        cycle(1'b1);
        check("queue_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
